// File: rtl/spawn_req_arbiter.sv
// Round-robin arbiter sharing one spawn engine between 8 one-pulse button requesters,
// with per-channel tick-based cooldown. Define ARB_FIXED_PRIORITY_EN for fixed-priority arbitration.
module spawn_req_arbiter #(
  parameter int N        = 8,
  parameter int CD_W     = 4,
  parameter int COOLDOWN = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [7:0] req,
  input  logic       ready,
  output logic       valid,
  output logic [2:0] grant_id,
  output logic [7:0] pending,
  output logic [7:0] cooling,
  output logic       fsm_state
);

  // Handshake: a grant is offered while valid=1 and transfers on any edge
  // where valid=1 and ready=1; valid/grant_id never change before that edge.
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [2:0]      grant_id_d;
  logic [7:0]      pending_d;
  logic [2:0]      pick;
  logic            hs;
  logic [CD_W-1:0] cnt_q [N];

  assign valid     = (state_q == GRANT);
  assign fsm_state = state_q;
  assign hs        = valid && ready;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    pick = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) pick = 3'(i);
    end
  end
`else
  logic [2:0] last_q;

  // Walk from farthest to nearest so the channel right after last wins.
  always_comb begin
    logic [2:0] idx;
    pick = '0;
    idx  = '0;
    for (int k = N; k >= 1; k--) begin
      idx = last_q + 3'(k);
      if (pending[idx]) pick = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  last_q <= 3'd7;
    else if (hs) last_q <= grant_id;
  end
`endif

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id;
    case (state_q)
      IDLE: begin
        if (|pending) begin
          state_d    = GRANT;
          grant_id_d = pick;
        end
      end
      GRANT: begin
        if (ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulses that cannot be latched right now are dropped, never queued.
  always_comb begin
    pending_d = pending;
    for (int i = 0; i < N; i++) begin
      if (hs && grant_id == 3'(i))
        pending_d[i] = 1'b0;
      else if (req[i] && !cooling[i] && !pending[i] && !(valid && grant_id == 3'(i)))
        pending_d[i] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) cooling[i] = (cnt_q[i] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_id <= '0;
      pending  <= '0;
    end else begin
      state_q  <= state_d;
      grant_id <= grant_id_d;
      pending  <= pending_d;
    end
  end

  // A handshake load beats a same-cycle tick decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (hs && grant_id == 3'(i))
          cnt_q[i] <= CD_W'(COOLDOWN);
        else if (tick && cnt_q[i] != '0)
          cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spawn_req_arbiter.sv
// Directed bench for spawn_req_arbiter (COOLDOWN=3): vector table plus
// hand-written backpressure and asynchronous-reset sequences.
module tb_spawn_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [7:0] req;
  logic       ready;
  logic       valid;
  logic [2:0] grant_id;
  logic [7:0] pending;
  logic [7:0] cooling;
  logic       fsm_state;

  int n_pass  = 0;
  int n_total = 0;

  logic [2:0] exp_q[$];

  typedef struct {
    logic [7:0] req;
    logic       ready;
    logic       tick;
    logic       v;
    logic [2:0] g;
    logic [7:0] p;
    logic [7:0] c;
  } vec_t;

  vec_t vecs[$];

  spawn_req_arbiter #(.N(8), .CD_W(4), .COOLDOWN(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .req       (req),
    .ready     (ready),
    .valid     (valid),
    .grant_id  (grant_id),
    .pending   (pending),
    .cooling   (cooling),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic step(input logic [7:0] r, input logic rd, input logic t);
    @(negedge clk);
    req   = r;
    ready = rd;
    tick  = t;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [7:0] r, input logic rd, input logic t,
                     input logic v, input logic [2:0] g, input logic [7:0] p, input logic [7:0] c);
    vec_t e;
    e.req = r; e.ready = rd; e.tick = t; e.v = v; e.g = g; e.p = p; e.c = c;
    vecs.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    req   = '0;
    ready = 1'b0;

    //  req    rdy  tk   v  g     pend   cool
    add(8'h00, 1, 0,   0, 0, 8'h00, 8'h00);
    add(8'h01, 1, 0,   0, 0, 8'h01, 8'h00);
    add(8'h00, 1, 0,   1, 0, 8'h01, 8'h00);
    add(8'h00, 1, 0,   0, 0, 8'h00, 8'h01);
    add(8'h0A, 1, 0,   0, 0, 8'h0A, 8'h01);
    add(8'h00, 1, 0,   1, 1, 8'h0A, 8'h01);
    add(8'h00, 1, 0,   0, 0, 8'h08, 8'h03);
    add(8'h00, 1, 0,   1, 3, 8'h08, 8'h03);
    add(8'h00, 1, 0,   0, 0, 8'h00, 8'h0B);
    add(8'h00, 0, 1,   0, 0, 8'h00, 8'h0B);
    add(8'h00, 0, 1,   0, 0, 8'h00, 8'h0B);
    add(8'h00, 0, 1,   0, 0, 8'h00, 8'h00);
    // round-robin: channel 5 granted, then 0 and 5 pending -> 0 first
    add(8'h20, 0, 0,   0, 0, 8'h20, 8'h00);
    add(8'h00, 0, 0,   1, 5, 8'h20, 8'h00);
    add(8'h00, 1, 0,   0, 0, 8'h00, 8'h20);
    add(8'h00, 0, 1,   0, 0, 8'h00, 8'h20);
    add(8'h00, 0, 1,   0, 0, 8'h00, 8'h20);
    add(8'h00, 0, 1,   0, 0, 8'h00, 8'h00);
    add(8'h21, 0, 0,   0, 0, 8'h21, 8'h00);
    add(8'h00, 0, 0,   1, 0, 8'h21, 8'h00);
    add(8'h00, 1, 0,   0, 0, 8'h20, 8'h01);
    add(8'h00, 1, 0,   1, 5, 8'h20, 8'h01);
    add(8'h00, 1, 0,   0, 0, 8'h00, 8'h21);
    add(8'h00, 0, 1,   0, 0, 8'h00, 8'h21);
    add(8'h00, 0, 1,   0, 0, 8'h00, 8'h21);
    add(8'h00, 0, 1,   0, 0, 8'h00, 8'h00);
    // cooldown on channel 2 with requests between ticks
    add(8'h04, 1, 0,   0, 0, 8'h04, 8'h00);
    add(8'h00, 1, 0,   1, 2, 8'h04, 8'h00);
    add(8'h00, 1, 0,   0, 0, 8'h00, 8'h04);
    add(8'h00, 0, 1,   0, 0, 8'h00, 8'h04);
    add(8'h04, 0, 0,   0, 0, 8'h00, 8'h04);
    add(8'h00, 0, 1,   0, 0, 8'h00, 8'h04);
    add(8'h04, 0, 0,   0, 0, 8'h00, 8'h04);
    add(8'h04, 0, 1,   0, 0, 8'h00, 8'h00);
    add(8'h04, 0, 0,   0, 0, 8'h04, 8'h00);
    add(8'h00, 1, 0,   1, 2, 8'h04, 8'h00);
    add(8'h00, 1, 0,   0, 0, 8'h00, 8'h04);
    add(8'h00, 0, 1,   0, 0, 8'h00, 8'h04);
    add(8'h00, 0, 1,   0, 0, 8'h00, 8'h04);
    add(8'h00, 0, 1,   0, 0, 8'h00, 8'h00);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_valid",   32'(valid),     32'd0);
    chk("reset_gid",     32'(grant_id),  32'd0);
    chk("reset_pending", 32'(pending),   32'd0);
    chk("reset_cooling", 32'(cooling),   32'd0);
    chk("reset_state",   32'(fsm_state), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].req, vecs[i].ready, vecs[i].tick);
      chk($sformatf("vec%0d_valid", i),   32'(valid),   32'(vecs[i].v));
      if (vecs[i].v)
        chk($sformatf("vec%0d_gid", i),   32'(grant_id), 32'(vecs[i].g));
      chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].p));
      chk($sformatf("vec%0d_cooling", i), 32'(cooling), 32'(vecs[i].c));
    end

    // backpressure on channel 4; duplicate req[4] dropped, req[6] latched
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd6);
    step(8'h10, 0, 0);
    chk("bp_latch", 32'(pending), 32'h10);
    step(8'h00, 0, 0);
    chk("bp_valid", 32'(valid), 32'd1);
    chk("bp_gid0",  32'(grant_id), 32'(exp_q.pop_front()));
    for (int k = 0; k < 20; k++) begin
      step((k == 3) ? 8'h10 : (k == 5) ? 8'h40 : 8'h00, 0, 0);
      chk($sformatf("bp_hold_valid%0d", k), 32'(valid),    32'd1);
      chk($sformatf("bp_hold_gid%0d", k),   32'(grant_id), 32'd4);
    end
    chk("bp_pending", 32'(pending), 32'h50);
    step(8'h00, 1, 0);
    chk("bp_hs_valid",   32'(valid),   32'd0);
    chk("bp_hs_pending", 32'(pending), 32'h40);
    chk("bp_hs_cooling", 32'(cooling), 32'h10);
    step(8'h00, 1, 0);
    chk("bp_next_valid", 32'(valid), 32'd1);
    chk("bp_next_gid",   32'(grant_id), 32'(exp_q.pop_front()));
    step(8'h00, 1, 0);
    chk("bp_done_pending", 32'(pending), 32'h00);
    chk("bp_done_cooling", 32'(cooling), 32'h50);

    // asynchronous reset in the middle of a grant
    step(8'h01, 0, 0);
    step(8'h08, 0, 0);
    chk("rst_pre_valid",   32'(valid),   32'd1);
    chk("rst_pre_pending", 32'(pending), 32'h09);
    step(8'h00, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid",   32'(valid),     32'd0);
    chk("rst_async_pending", 32'(pending),   32'h00);
    chk("rst_async_cooling", 32'(cooling),   32'h00);
    chk("rst_async_state",   32'(fsm_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h81, 0, 0);
    chk("post_rst_pending", 32'(pending), 32'h81);
    step(8'h00, 0, 0);
    chk("post_rst_valid", 32'(valid),    32'd1);
    chk("post_rst_gid",   32'(grant_id), 32'd0);
    step(8'h00, 1, 0);
    chk("post_rst_hs_pending", 32'(pending), 32'h80);
    step(8'h00, 1, 0);
    chk("post_rst_gid2", 32'(grant_id), 32'd7);
    chk("post_rst_valid2", 32'(valid), 32'd1);
    step(8'h00, 1, 0);
    chk("post_rst_final_pending", 32'(pending), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
